// File: rtl/wbuf_pkg.sv
// rtl/wbuf_pkg.sv - shared entry type and word-match helper for the dmem write buffer
package wbuf_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbuf_entry_t;

    // Word granularity: callers pass address bits [31:2] only.
    function automatic logic word_match(input logic [ADDR_W-3:0] a, input logic [ADDR_W-3:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// rtl/wbuf_fifo.sv - in-order store FIFO: storage, head/tail pointers, occupancy count
import wbuf_pkg::*;

module wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  wbuf_entry_t               push_entry,
    input  logic                      pop,
    output wbuf_entry_t [DEPTH-1:0]   entries,
    output logic        [PW-1:0]      head,
    output logic        [CW-1:0]      count,
    output logic                      full,
    output logic                      empty
);

    wbuf_entry_t [DEPTH-1:0] store_q;
    logic        [PW-1:0]    tail;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign entries = store_q;

    // Pointers are PW bits wide, so DEPTH being a power of two gives the wrap for free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            store_q[tail] <= push_entry;
        end
    end

endmodule

// File: rtl/dmem_write_buffer.sv
// rtl/dmem_write_buffer.sv - store buffer between core and dmem; WB_FORWARD_EN enables load forwarding
import wbuf_pkg::*;

module dmem_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_write,
    input  logic        cpu_read,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_write_data,
    output logic [31:0] cpu_read_data,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic        mem_write_en,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wbuf_entry_t [DEPTH-1:0] entries;
    wbuf_entry_t             head_entry;
    wbuf_entry_t             push_entry;
    logic        [PW-1:0]    head;
    logic        [CW-1:0]    count;
    logic                    full;
    logic                    empty;

    logic                    ld_hit;
    logic                    ld_stall;
    logic                    load_now;
    logic                    drain;
    logic                    store;
    logic                    push;
    logic                    pop;
    logic                    wr_stall;
    logic        [PW-1:0]    slot;
`ifdef WB_FORWARD_EN
    logic        [31:0]      fwd_data;
`endif

    assign head_entry = entries[head];
    assign push_entry = '{addr: cpu_addr, data: cpu_write_data};

    // Walk pending entries oldest to youngest so the last hit is the youngest store.
    always_comb begin
        ld_hit   = 1'b0;
        slot     = '0;
`ifdef WB_FORWARD_EN
        fwd_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + PW'(i);
            if (i < int'(count) && word_match(entries[slot].addr[31:2], cpu_addr[31:2])) begin
                ld_hit   = 1'b1;
`ifdef WB_FORWARD_EN
                fwd_data = entries[slot].data;
`endif
            end
        end
    end

    always_comb begin
`ifdef WB_FORWARD_EN
        ld_stall = 1'b0;
`else
        ld_stall = cpu_read && ld_hit;
`endif
        // A blocked load gives up its memory slot so the matching stores can drain.
        load_now = cpu_read && !ld_stall;
        drain    = !empty && !load_now;
        pop      = drain && mem_ready;
        store    = cpu_write && !cpu_read;
        push     = store && (!full || pop);
        wr_stall = store && full && !pop;
    end

    always_comb begin
        mem_write_en   = drain && !reset;
        mem_addr       = drain ? head_entry.addr : cpu_addr;
        mem_write_data = head_entry.data;
        stall          = !reset && (wr_stall || ld_stall);
`ifdef WB_FORWARD_EN
        cpu_read_data  = (ld_hit && !reset) ? fwd_data : mem_read_data;
`else
        cpu_read_data  = mem_read_data;
`endif
    end

    wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .entries    (entries),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb/tb_dmem_write_buffer.sv - self-checking bench for dmem_write_buffer (queue reference model)
module tb_dmem_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_write;
    logic        cpu_read;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_write_data;
    logic [31:0] cpu_read_data;
    logic        stall;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_ready;

    logic [31:0] dmem    [1024];
    logic [31:0] exp_mem [1024];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic        rdy;
        logic        e_stall;
        logic        e_we;
        logic [31:0] e_maddr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;
    vec_t tbl[13];

    int  vectors    = 0;
    int  miscompares = 0;
    bit  m_pop, m_push, m_stall;

    always #5 clk = ~clk;

    assign mem_read_data = dmem[mem_addr[11:2]];

    dmem_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_write      (cpu_write),
        .cpu_read       (cpu_read),
        .cpu_addr       (cpu_addr),
        .cpu_write_data (cpu_write_data),
        .cpu_read_data  (cpu_read_data),
        .stall          (stall),
        .mem_addr       (mem_addr),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                                input logic rdy, input logic es, input logic ewe, input logic [31:0] ema,
                                input logic [31:0] ewd, input logic [31:0] erd);
        vec_t v;
        v = '{w, r, a, d, rdy, es, ewe, ema, ewd, erd};
        return v;
    endfunction

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        @(negedge clk);
        cpu_write      = w;
        cpu_read       = r;
        cpu_addr       = a;
        cpu_write_data = d;
        mem_ready      = rdy;
        #1;
    endtask

    // Reference behaviour straight from the buffer rules, on a queue of pending stores.
    task automatic model_eval(input bit check);
        int          hit;
        bit          ld_stall, load_now, drain, store, full;
        logic [31:0] e_addr, e_rdata;
        hit = -1;
        if (cpu_read) begin
            foreach (q[i]) if (q[i].addr[31:2] == cpu_addr[31:2]) hit = i;
        end
`ifdef WB_FORWARD_EN
        ld_stall = 1'b0;
`else
        ld_stall = cpu_read && (hit >= 0);
`endif
        load_now = cpu_read && !ld_stall;
        drain    = !load_now && (q.size() > 0);
        m_pop    = drain && mem_ready;
        store    = cpu_write && !cpu_read;
        full     = (q.size() == DEPTH);
        m_push   = store && (!full || m_pop);
        m_stall  = ld_stall || (store && full && !m_pop);
        e_addr   = drain ? q[0].addr : cpu_addr;
        if (check) begin
            chk("stall", stall, m_stall);
            chk("mem_write_en", mem_write_en, drain);
            chk("mem_addr", mem_addr, e_addr);
            if (drain) chk("mem_write_data", mem_write_data, q[0].data);
            if (load_now) begin
                e_rdata = (hit >= 0) ? q[hit].data : exp_mem[cpu_addr[11:2]];
                chk("cpu_read_data", cpu_read_data, e_rdata);
            end
        end
    endtask

    task automatic commit();
        logic        lwe, lrdy;
        logic [31:0] la, ld;
        ent_t        e;
        lwe  = mem_write_en;
        lrdy = mem_ready;
        la   = mem_addr;
        ld   = mem_write_data;
        e    = '{cpu_addr, cpu_write_data};
        @(posedge clk);
        if (lwe && lrdy) dmem[la[11:2]] = ld;
        if (m_pop) begin
            exp_mem[q[0].addr[11:2]] = q[0].data;
            void'(q.pop_front());
        end
        if (m_push) q.push_back(e);
    endtask

    task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        drive(w, r, a, d, rdy);
        model_eval(1);
        commit();
    endtask

    initial begin
        int ndiff;
        logic        hw, hr, hrdy;
        logic [31:0] ha, hd;

        for (int i = 0; i < 1024; i++) begin
            dmem[i]    = 32'hC000_0000 | i;
            exp_mem[i] = 32'hC000_0000 | i;
        end

        // Empty queue, store/drain, fill to full, load bypass of a non-matching store.
        tbl[0]  = mk(0, 0, 32'h000, 32'h00, 1, 0, 0, 32'h000, 32'h00, 32'h0);
        tbl[1]  = mk(1, 0, 32'h100, 32'h54, 1, 0, 0, 32'h100, 32'h00, 32'h0);
        tbl[2]  = mk(0, 0, 32'h000, 32'h00, 1, 0, 1, 32'h100, 32'h54, 32'h0);
        tbl[3]  = mk(0, 0, 32'h004, 32'h00, 1, 0, 0, 32'h004, 32'h00, 32'h0);
        tbl[4]  = mk(1, 0, 32'h400, 32'hA0, 0, 0, 0, 32'h400, 32'h00, 32'h0);
        tbl[5]  = mk(1, 0, 32'h404, 32'hA1, 0, 0, 1, 32'h400, 32'hA0, 32'h0);
        tbl[6]  = mk(1, 0, 32'h408, 32'hA2, 0, 0, 1, 32'h400, 32'hA0, 32'h0);
        tbl[7]  = mk(1, 0, 32'h40C, 32'hA3, 0, 0, 1, 32'h400, 32'hA0, 32'h0);
        tbl[8]  = mk(1, 0, 32'h410, 32'hA4, 0, 1, 1, 32'h400, 32'hA0, 32'h0);
        tbl[9]  = mk(1, 0, 32'h410, 32'hA4, 1, 0, 1, 32'h400, 32'hA0, 32'h0);
        tbl[10] = mk(0, 1, 32'h300, 32'h00, 1, 0, 0, 32'h300, 32'h00, 32'hC000_00C0);
        tbl[11] = mk(0, 0, 32'h000, 32'h00, 1, 0, 1, 32'h404, 32'hA1, 32'h0);
        tbl[12] = mk(0, 1, 32'h400, 32'h00, 1, 0, 0, 32'h400, 32'h00, 32'h0000_00A0);

        reset          = 1'b1;
        cpu_write      = 1'b1;
        cpu_read       = 1'b0;
        cpu_addr       = 32'h10;
        cpu_write_data = 32'hDEAD;
        mem_ready      = 1'b1;
        #2;
        chk("reset_stall", stall, 1'b0);
        chk("reset_we", mem_write_en, 1'b0);
        cpu_write = 1'b0;
        cpu_read  = 1'b1;
        #1;
        chk("reset_rdata", cpu_read_data, 32'hC000_0004);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].rdy);
            chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e_stall);
            chk($sformatf("tbl%0d_we", i), mem_write_en, tbl[i].e_we);
            chk($sformatf("tbl%0d_maddr", i), mem_addr, tbl[i].e_maddr);
            if (tbl[i].e_we) chk($sformatf("tbl%0d_wdata", i), mem_write_data, tbl[i].e_wdata);
            if (tbl[i].r && !tbl[i].e_stall) chk($sformatf("tbl%0d_rdata", i), cpu_read_data, tbl[i].e_rdata);
            model_eval(0);
            commit();
        end

        // Asynchronous reset with three stores pending.
        drive(0, 0, 32'h20, 32'h0, 0);
        model_eval(1);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_we", mem_write_en, 1'b0);
        chk("rst_async_stall", stall, 1'b0);
        cpu_read = 1'b1;
        cpu_addr = 32'h408;
        #1;
        chk("rst_load_stall", stall, 1'b0);
        chk("rst_load_rdata", cpu_read_data, 32'hC000_0102);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step(0, 0, 32'h20, 32'h0, 1);
        chk("rst_discarded", dmem[32'h408 >> 2], 32'hC000_0102);

        // Two stores to the same word, then a load of it.
        step(1, 0, 32'h200, 32'h11, 0);
        step(1, 0, 32'h200, 32'h22, 0);
        drive(0, 1, 32'h200, 32'h0, 0);
        model_eval(1);
`ifdef WB_FORWARD_EN
        chk("fwd_rdata", cpu_read_data, 32'h22);
        chk("fwd_stall", stall, 1'b0);
        commit();
        repeat (2) step(0, 0, 32'h0, 32'h0, 1);
`else
        chk("raw_stall", stall, 1'b1);
        commit();
        step(0, 1, 32'h200, 32'h0, 1);
        step(0, 1, 32'h200, 32'h0, 1);
        drive(0, 1, 32'h200, 32'h0, 1);
        model_eval(1);
        chk("raw_stall_drop", stall, 1'b0);
        chk("raw_rdata", cpu_read_data, 32'h22);
        commit();
`endif

        // Pointer wrap: fill to three, then ten simultaneous push/pop cycles.
        for (int i = 0; i < 3; i++) step(1, 0, 32'h500 + 4 * i, 32'hB0 + i, 0);
        for (int i = 3; i < 13; i++) step(1, 0, 32'h500 + 4 * i, 32'hB0 + i, 1);
        for (int i = 0; i < 8 && q.size() > 0; i++) step(0, 0, 32'h0, 32'h0, 1);
        chk("wrap_drained", q.size(), 0);
        chk("wrap_last_word", dmem[(32'h500 + 4 * 12) >> 2], 32'hBC);

        // Random traffic; inputs are held while the model expects a stall.
        hw = 0; hr = 0; ha = 0; hd = 0;
        m_stall = 0;
        for (int n = 0; n < 400; n++) begin
            if (!m_stall) begin
                hw = ($urandom_range(0, 99) < 45);
                hr = ($urandom_range(0, 99) < 35);
                if (hw && hr && $urandom_range(0, 99) < 80) hw = 0;
                ha = 32'h200 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
                hd = $urandom;
            end
            hrdy = ($urandom_range(0, 99) < 55);
            step(hw, hr, ha, hd, hrdy);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) step(0, 0, 32'h0, 32'h0, 1);
        chk("final_drained", q.size(), 0);
        ndiff = 0;
        for (int i = 0; i < 1024; i++) if (dmem[i] !== exp_mem[i]) ndiff++;
        chk("final_memory_words_differing", ndiff, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_write_buffer.md
DMEM_WRITE_BUFFER -- requirements
Module: dmem_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cpu_write  input  1  core store request (word).
REQ-005 SHALL have port cpu_read  input  1  core load request (word).
REQ-006 SHALL have port cpu_addr  input  32  core byte address; word match uses bits [31:2].
REQ-007 SHALL have port cpu_write_data  input  32  store data.
REQ-008 SHALL have port cpu_read_data  output  32  load data, combinational.
REQ-009 SHALL have port stall  output  1  core must hold its request and inputs while high.
REQ-010 SHALL have port mem_addr  output  32  dmem address.
REQ-011 SHALL have port mem_write_en  output  1  dmem write strobe.
REQ-012 SHALL have port mem_write_data  output  32  dmem write data.
REQ-013 SHALL have port mem_read_data  input  32  dmem combinational read data.
REQ-014 SHALL have port mem_ready  input  1  dmem accepts a write this cycle.

Function
REQ-015 SHALL hold stores in an in-order FIFO of DEPTH {addr, data} entries with head, tail and count (count 0..DEPTH, pointers wrap modulo DEPTH).
REQ-016 SHALL, when cpu_read=1, drive mem_addr=cpu_addr, mem_write_en=0; loads have priority over draining.
REQ-017 SHALL, when cpu_read=0 and count>0, drive mem_addr/mem_write_data from head entry and mem_write_en=1; pop occurs at the edge only if mem_ready=1.
REQ-018 SHALL, when cpu_read=0 and count=0, drive mem_write_en=0, mem_addr=cpu_addr.
REQ-019 SHALL push a store at the edge when cpu_write=1 and (count<DEPTH or a pop occurs that cycle); stall=0.
REQ-020 SHALL assert stall for a store when count=DEPTH and no pop occurs that cycle; no push.
REQ-021 SHALL allow simultaneous push and pop; count unchanged, pointers both advance.
REQ-022 SHALL treat cpu_read and cpu_write both high as illegal; behaviour is the load rule, store ignored.
REQ-023 SHALL return mem_read_data for a load with no pending entry matching addr[31:2].
REQ-024 SHALL forward matching loads per REQ-030/031.
REQ-025 SHALL never reorder stores to memory; drain order equals push order.

Reset
REQ-026 SHALL, on reset assertion, immediately clear count, head, tail; pending stores discarded.
REQ-027 SHALL force mem_write_en=0 and stall=0 while reset is high, regardless of inputs.
REQ-028 SHALL output cpu_read_data=mem_read_data while reset is high (count=0).
REQ-029 SHALL resume normal operation on the first rising edge after reset deasserts.

Configuration
REQ-030 SHALL, with WB_FORWARD_EN defined, return the data of the youngest matching pending entry for a load, stall=0, latency zero (same cycle).
REQ-031 SHALL, without WB_FORWARD_EN, assert stall on a load matching any pending entry; drain continues (load priority suspended for that cycle so drain may proceed) until no match, then load completes from memory.

Structure
REQ-032 SHALL place the entry typedef {addr[31:0], data[31:0]} and word-match helper in package wbuf_pkg.
REQ-033 SHALL use one sub-module wbuf_fifo (storage, pointers, count, full/empty); match/forward logic stays in the top.

Verification
REQ-034 Store 0x54->0x100 with mem_ready=1, no loads -> mem_write_en=1, mem_addr=0x100, mem_write_data=0x54 next cycle; count returns 0.
REQ-035 mem_ready=0, 5 stores (DEPTH=4) -> 5th asserts stall; mem_ready=1 one cycle -> pop+push same edge, stall drops, count stays 4.
REQ-036 Stores 0x11 then 0x22 to 0x200 pending, load 0x200 (WB_FORWARD_EN) -> cpu_read_data=0x22, stall=0; without macro -> stall until both drain, then 0x22 from memory.
REQ-037 Load 0x300 while store to 0x200 pending -> mem_addr=0x300, mem_write_en=0, mem_read_data returned, queue unchanged.
REQ-038 Reset asserted mid-cycle with 3 pending -> mem_write_en drops immediately, count=0, no further writes after release.
REQ-039 Pointer wrap: 10 push/pop pairs at DEPTH=4 -> memory writes in exact push order, no loss.
